// File: rtl/cpu_debug_scan_pkg.sv
// Shared types and constants for the CPU virtual-JTAG debug scan master.
package cpu_debug_scan_pkg;

  localparam int unsigned DR_WIDTH_DEFAULT = 38;

  // IR opcodes understood by the CPU debug module
  localparam logic [1:0] IR_OCIMEM    = 2'b00;
  localparam logic [1:0] IR_TRACEMEM  = 2'b01;
  localparam logic [1:0] IR_BREAK     = 2'b10;
  localparam logic [1:0] IR_TRACECTRL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    UIR,
    CDR,
    SDR,
    UDR,
    RTI,
    RESP
  } scan_state_t;

endpackage

// File: rtl/cpu_debug_scan_tckgen.sv
// Test-clock divider: TCK_DIV clk cycles low then TCK_DIV high per tck period,
// with pulses on the last low cycle (pre_rise_c) and the last high cycle (period_end_c).
module cpu_debug_scan_tckgen #(
  parameter int unsigned TCK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic vji_tck,
  output logic period_end_c,
  output logic pre_rise_c
);

  localparam int unsigned PERIOD = 2 * TCK_DIV;
  localparam int unsigned CW     = $clog2(PERIOD);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  // Counter parks at zero whenever no scan phase is active
  always_comb begin
    cnt_nxt = '0;
    if (run && (cnt != CW'(PERIOD - 1))) begin
      cnt_nxt = cnt + CW'(1);
    end
  end

  assign period_end_c = run && (cnt == CW'(PERIOD - 1));
  assign pre_rise_c   = run && (cnt == CW'(TCK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      vji_tck <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      vji_tck <= (cnt_nxt >= CW'(TCK_DIV));
    end
  end

endmodule

// File: rtl/cpu_debug_scan_master.sv
// Virtual-JTAG scan initiator: runs UIR/CDR/SDR/UDR for one command and returns the DR.
// Optional macro DBG_SCAN_RTI_CYCLES_EN adds RTI_CYCLES tck periods of run-test-idle after UDR.
module cpu_debug_scan_master
  import cpu_debug_scan_pkg::*;
#(
  parameter int unsigned DR_WIDTH   = DR_WIDTH_DEFAULT,
  parameter int unsigned IR_WIDTH   = 2,
  parameter int unsigned TCK_DIV    = 4,
  parameter int unsigned RTI_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  input  logic                cmd_ir_only,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                vji_tck,
  output logic                vji_tdi,
  input  logic                vji_tdo,
  output logic [IR_WIDTH-1:0] vji_ir_in,
  input  logic [IR_WIDTH-1:0] vji_ir_out,
  output logic                vji_uir,
  output logic                vji_cdr,
  output logic                vji_sdr,
  output logic                vji_udr,
  output logic                vji_rti
);

`ifdef DBG_SCAN_RTI_CYCLES_EN
  localparam bit RTI_EN = 1'b1;
`else
  localparam bit RTI_EN = 1'b0;
`endif

  localparam bit          RTI_ON   = RTI_EN && (RTI_CYCLES > 0);
  localparam int unsigned RW       = (RTI_CYCLES > 1) ? $clog2(RTI_CYCLES) : 1;
  localparam int unsigned RTI_LAST = (RTI_CYCLES > 0) ? RTI_CYCLES - 1 : 0;
  localparam int unsigned BW       = $clog2(DR_WIDTH + 1);

  scan_state_t         state;
  logic [DR_WIDTH-1:0] shreg;
  logic [DR_WIDTH-1:0] shreg_shr;
  logic [DR_WIDTH-1:0] cap;
  logic [DR_WIDTH-1:0] cap_ins;
  logic                ir_only;
  logic [BW-1:0]       bit_cnt;
  logic [RW-1:0]       rti_cnt;
  logic                run_c;
  logic                period_end_c;
  logic                pre_rise_c;

  assign run_c = (state == UIR) || (state == CDR) || (state == SDR) ||
                 (state == UDR) || (state == RTI);

  cpu_debug_scan_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk          (clk),
    .reset        (reset),
    .run          (run_c),
    .vji_tck      (vji_tck),
    .period_end_c (period_end_c),
    .pre_rise_c   (pre_rise_c)
  );

  // tdo enters at the MSB so that after DR_WIDTH bits capture bit i holds the i-th tdo bit
  always_comb begin
    shreg_shr            = shreg >> 1;
    cap_ins              = cap >> 1;
    cap_ins[DR_WIDTH-1]  = vji_tdo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
      vji_tdi    <= 1'b0;
      vji_ir_in  <= '0;
      vji_uir    <= 1'b0;
      vji_cdr    <= 1'b0;
      vji_sdr    <= 1'b0;
      vji_udr    <= 1'b0;
      vji_rti    <= 1'b0;
      shreg      <= '0;
      cap        <= '0;
      ir_only    <= 1'b0;
      bit_cnt    <= '0;
      rti_cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            vji_rti   <= 1'b0;
            vji_uir   <= 1'b1;
            vji_ir_in <= cmd_ir;
            shreg     <= cmd_dr;
            cap       <= '0;
            ir_only   <= cmd_ir_only;
            state     <= UIR;
          end else begin
            cmd_ready <= 1'b1;
            vji_rti   <= 1'b1;
          end
        end
        UIR: begin
          if (period_end_c) begin
            vji_uir <= 1'b0;
            if (ir_only) begin
              rsp_ir_out <= vji_ir_out;
              rsp_dr     <= cap;
              rsp_valid  <= 1'b1;
              state      <= RESP;
            end else begin
              vji_cdr <= 1'b1;
              state   <= CDR;
            end
          end
        end
        CDR: begin
          if (period_end_c) begin
            vji_cdr <= 1'b0;
            vji_sdr <= 1'b1;
            vji_tdi <= shreg[0];
            bit_cnt <= '0;
            state   <= SDR;
          end
        end
        SDR: begin
          if (pre_rise_c) begin
            cap <= cap_ins;
          end
          if (period_end_c) begin
            if (bit_cnt == BW'(DR_WIDTH - 1)) begin
              vji_sdr <= 1'b0;
              vji_tdi <= 1'b0;
              vji_udr <= 1'b1;
              state   <= UDR;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shreg   <= shreg_shr;
              vji_tdi <= shreg_shr[0];
            end
          end
        end
        UDR: begin
          if (period_end_c) begin
            vji_udr    <= 1'b0;
            rsp_ir_out <= vji_ir_out;
            if (RTI_ON) begin
              vji_rti <= 1'b1;
              rti_cnt <= '0;
              state   <= RTI;
            end else begin
              rsp_dr    <= cap;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        RTI: begin
          if (period_end_c) begin
            if (rti_cnt == RW'(RTI_LAST)) begin
              vji_rti   <= 1'b0;
              rsp_dr    <= cap;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end else begin
              rti_cnt <= rti_cnt + RW'(1);
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            vji_rti   <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_debug_scan_master.sv
// Directed + randomized bench for cpu_debug_scan_master with a tck-domain loopback target model.
module tb_cpu_debug_scan_master;
  import cpu_debug_scan_pkg::*;

  localparam int unsigned DW = 38;
  localparam int unsigned IW = 2;
  localparam int unsigned TD = 4;
  localparam int unsigned RC = 2;
`ifdef DBG_SCAN_RTI_CYCLES_EN
  localparam int unsigned RTI_CLK = RC * 2 * TD;
`else
  localparam int unsigned RTI_CLK = 0;
`endif
  localparam int unsigned FULL_LAT = 1 + (3 + DW) * 2 * TD + RTI_CLK;
  localparam int unsigned IRO_LAT  = 1 + 2 * TD;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [IW-1:0] cmd_ir = '0;
  logic [DW-1:0] cmd_dr = '0;
  logic          cmd_ir_only = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_dr;
  logic [IW-1:0] rsp_ir_out;
  logic          vji_tck, vji_tdi, vji_tdo;
  logic [IW-1:0] vji_ir_in;
  logic [IW-1:0] vji_ir_out = '0;
  logic          vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti;

  int total = 0;
  int bad = 0;
  int n_uir, n_cdr, n_sdr, n_udr, n_rti, n_rise, n_rdy;

  logic [DW-1:0] tgt_sr = '0;
  logic [DW-1:0] tgt_rx = '0;
  logic [DW-1:0] tgt_preload = '0;

  always #5 clk = ~clk;

  cpu_debug_scan_master #(
    .DR_WIDTH   (DW),
    .IR_WIDTH   (IW),
    .TCK_DIV    (TD),
    .RTI_CYCLES (RC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_ir      (cmd_ir),
    .cmd_dr      (cmd_dr),
    .cmd_ir_only (cmd_ir_only),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_dr      (rsp_dr),
    .rsp_ir_out  (rsp_ir_out),
    .vji_tck     (vji_tck),
    .vji_tdi     (vji_tdi),
    .vji_tdo     (vji_tdo),
    .vji_ir_in   (vji_ir_in),
    .vji_ir_out  (vji_ir_out),
    .vji_uir     (vji_uir),
    .vji_cdr     (vji_cdr),
    .vji_sdr     (vji_sdr),
    .vji_udr     (vji_udr),
    .vji_rti     (vji_rti)
  );

  // Target data register: loads at CDR, shifts one bit per SDR tck rise
  assign vji_tdo = tgt_sr[0];
  always @(posedge vji_tck) begin
    if (vji_cdr) begin
      tgt_sr <= tgt_preload;
    end else if (vji_sdr) begin
      tgt_sr <= tgt_sr >> 1;
      tgt_rx <= {vji_tdi, tgt_rx[DW-1:1]};
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_dr();
    return DW'({$urandom(), $urandom()});
  endfunction

  // Offer a command; returns at the sample point of the cycle in which it is accepted
  task automatic start_cmd(input logic [IW-1:0] ir, input logic [DW-1:0] dr, input logic only);
    int w;
    w = 0;
    cmd_ir = ir;
    cmd_dr = dr;
    cmd_ir_only = only;
    cmd_valid = 1'b1;
    while (!cmd_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    if (w >= 1000) chk("accept_timeout", 64'(1), 64'(0));
  endtask

  // Counts clk cycles after acceptance until rsp_valid, tallying strobe activity
  task automatic wait_rsp(output int lat);
    logic prev_tck;
    prev_tck = 1'b0;
    n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; n_rise = 0; n_rdy = 0;
    lat = 0;
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      if (lat == 1) cmd_valid = 1'b0;
      if (rsp_valid) break;
      n_uir += int'(vji_uir);
      n_cdr += int'(vji_cdr);
      n_sdr += int'(vji_sdr);
      n_udr += int'(vji_udr);
      n_rti += int'(vji_rti);
      n_rdy += int'(cmd_ready);
      if (vji_rti && vji_tck && !prev_tck) n_rise++;
      prev_tck = vji_tck;
    end
    if (!rsp_valid) chk("rsp_timeout", 64'(1), 64'(0));
  endtask

  task automatic full_scan(input string tag, input logic [IW-1:0] ir, input logic [DW-1:0] dr,
                           input logic [DW-1:0] pre, input logic [IW-1:0] iro);
    int lat;
    tgt_preload = pre;
    vji_ir_out = iro;
    start_cmd(ir, dr, 1'b0);
    wait_rsp(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(FULL_LAT));
    chk({tag, "_uir_cycles"}, 64'(n_uir), 64'(2 * TD));
    chk({tag, "_cdr_cycles"}, 64'(n_cdr), 64'(2 * TD));
    chk({tag, "_sdr_cycles"}, 64'(n_sdr), 64'(DW * 2 * TD));
    chk({tag, "_udr_cycles"}, 64'(n_udr), 64'(2 * TD));
    chk({tag, "_rti_cycles"}, 64'(n_rti), 64'(RTI_CLK));
    chk({tag, "_rti_tck_rises"}, 64'(n_rise), 64'(RTI_CLK / (2 * TD)));
    chk({tag, "_ready_while_busy"}, 64'(n_rdy), 64'(0));
    chk({tag, "_target_rx"}, 64'(tgt_rx), 64'(dr));
    chk({tag, "_rsp_dr"}, 64'(rsp_dr), 64'(pre));
    chk({tag, "_rsp_ir_out"}, 64'(rsp_ir_out), 64'(iro));
    chk({tag, "_ir_in"}, 64'(vji_ir_in), 64'(ir));
  endtask

  task automatic ir_scan(input string tag, input logic [IW-1:0] ir, input logic [IW-1:0] iro);
    int lat;
    vji_ir_out = iro;
    start_cmd(ir, rnd_dr(), 1'b1);
    wait_rsp(lat);
    chk({tag, "_latency"}, 64'(lat), 64'(IRO_LAT));
    chk({tag, "_uir_cycles"}, 64'(n_uir), 64'(2 * TD));
    chk({tag, "_other_strobes"}, 64'(n_cdr + n_sdr + n_udr + n_rti), 64'(0));
    chk({tag, "_rsp_ir_out"}, 64'(rsp_ir_out), 64'(iro));
    chk({tag, "_ir_in"}, 64'(vji_ir_in), 64'(ir));
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_valid_cleared"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_cmd_ready_back"}, 64'(cmd_ready), 64'(1));
  endtask

  initial begin
    logic [IW-1:0] ir_tab [4];
    logic [DW-1:0] dr2, pre2, pre1;
    int stall_err, rsp_seen;
    ir_tab = '{IR_OCIMEM, IR_TRACEMEM, IR_BREAK, IR_TRACECTRL};

    // Reset, then idle
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_tck", 64'(vji_tck), 64'(0));
    chk("idle_strobes", 64'({vji_uir, vji_cdr, vji_sdr, vji_udr}), 64'(0));
    chk("idle_rti", 64'(vji_rti), 64'(1));
    chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("idle_ir_in", 64'(vji_ir_in), 64'(0));

    // Loopback scan with the documented patterns
    full_scan("loop", IR_BREAK, 38'h15_A5A5_A5A5, 38'h2A_5A5A_5A5A, 2'b10);
    consume("loop");

    // IR-only command
    ir_scan("iro", IR_TRACECTRL, 2'b01);
    consume("iro");

    // Response back-pressure with a second command pending
    pre1 = rnd_dr();
    full_scan("bp1", ir_tab[$urandom_range(3)], rnd_dr(), pre1, IW'($urandom()));
    dr2 = rnd_dr();
    pre2 = rnd_dr();
    cmd_ir = IR_OCIMEM;
    cmd_dr = dr2;
    cmd_ir_only = 1'b0;
    cmd_valid = 1'b1;
    stall_err = 0;
    repeat (50) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_dr !== pre1 || cmd_ready !== 1'b0) stall_err++;
    end
    chk("bp_stall_stable", 64'(stall_err), 64'(0));
    consume("bp_release");
    full_scan("bp2", IR_OCIMEM, dr2, pre2, 2'b11);
    consume("bp2");

    // Reset during bit 17 of SDR
    tgt_preload = rnd_dr();
    start_cmd(IR_TRACEMEM, rnd_dr(), 1'b0);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (154) @(negedge clk);
    chk("abort_in_sdr", 64'(vji_sdr), 64'(1));
    reset = 1'b1;
    @(negedge clk);
    chk("abort_sdr", 64'(vji_sdr), 64'(0));
    chk("abort_tck", 64'(vji_tck), 64'(0));
    chk("abort_ir_in", 64'(vji_ir_in), 64'(0));
    chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    reset = 1'b0;
    rsp_seen = 0;
    repeat (400) begin
      @(negedge clk);
      rsp_seen += int'(rsp_valid);
    end
    chk("abort_no_rsp", 64'(rsp_seen), 64'(0));
    full_scan("post_abort", IR_BREAK, rnd_dr(), rnd_dr(), 2'b01);
    consume("post_abort");

    // Random commands with rsp_ready held high
    for (int i = 0; i < 5; i++) begin
      rsp_ready = 1'b1;
      if ($urandom_range(3) == 0)
        ir_scan("rnd_iro", ir_tab[$urandom_range(3)], IW'($urandom()));
      else
        full_scan("rnd_full", ir_tab[$urandom_range(3)], rnd_dr(), rnd_dr(), IW'($urandom()));
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rnd_one_cycle_rsp", 64'(rsp_valid), 64'(0));
      chk("rnd_ready_back", 64'(cmd_ready), 64'(1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
